// File: rtl/prng_pkg.sv
// Shared definitions for the PRNG stream engine family: FSM encodings, CSR status codes
// and default Fibonacci LFSR tap masks.
package prng_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_RUN     = 3'd2;
  localparam state_t S_PRESENT = 3'd3;
  localparam state_t S_FINISH  = 3'd4;

  localparam logic [2:0] ST_BUSY  = 3'b010;
  localparam logic [2:0] ST_DONE  = 3'b001;
  localparam logic [2:0] ST_ABORT = 3'b100;

  // Maximal-length tap sets (bit i set means state[i] feeds the XOR)
  localparam logic [7:0]   TAPS_8   = 8'hB8;
  localparam logic [31:0]  TAPS_32  = 32'h8020_0003;
  localparam logic [63:0]  TAPS_64  = 64'hD800_0000_0000_0000;
  localparam logic [127:0] TAPS_128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

endpackage

// File: rtl/prng_stream_engine_if.sv
// Generated-word stream: word plus valid/ready handshake between engine and consumer.
interface prng_stream_engine_if #(
  parameter int unsigned WIDTH = 128
);
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic             word_ready_i;

  modport master (output word_o, output word_valid_o, input word_ready_i);
  modport slave  (input word_o, input word_valid_o, output word_ready_i);
endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: shift left, feedback is the parity of the tapped bits.
module lfsr_step
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH = 128,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_128)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);
  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/prng_stream_engine.sv
// Burst PRNG engine: emits count_i LFSR words, SHIFTS steps apart, over a valid/ready stream,
// with reseed/continue, abort, zero-seed substitution and CSR status strobes.
module prng_stream_engine
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH  = 128,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(TAPS_128),
  parameter int unsigned      SHIFTS = 16,
  parameter int unsigned      CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     seed_i,
  input  logic                 seed_we_i,
  input  logic                 start_i,
  input  logic                 reseed_i,
  input  logic [CNT_W-1:0]     count_i,
  input  logic                 abort_i,
  prng_stream_engine_if.master strm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           status_o,
  output logic                 status_we_o,
  output logic                 seed_err_o
);
  localparam int unsigned SH_W = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt, seed_q, word_q, word_d, load_val;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             reseed_q, reseed_d, err_q, err_d;

  lfsr_step #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_step (
    .cur(lfsr_q),
    .nxt(lfsr_nxt)
  );

  assign load_val = reseed_q ? seed_q : lfsr_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    word_d   = word_q;
    rem_d    = rem_q;
    sh_d     = sh_q;
    reseed_d = reseed_q;
    err_d    = err_q;
    if (state_q != S_IDLE && abort_i) begin
      // Abort beats any same-cycle handshake; the LFSR is left where it is
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_d    = count_i;
            reseed_d = reseed_i;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_val == '0) begin
            lfsr_d = WIDTH'(1);
            err_d  = 1'b1;
          end else begin
            lfsr_d = load_val;
          end
          sh_d    = '0;
          state_d = (rem_q == '0) ? S_FINISH : S_RUN;
        end
        S_RUN: begin
          lfsr_d = lfsr_nxt;
          sh_d   = sh_q + SH_W'(1);
          if (sh_q == SH_W'(SHIFTS - 1)) begin
            word_d  = lfsr_nxt;
            state_d = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (strm.word_ready_i) begin
            rem_d   = rem_q - CNT_W'(1);
            sh_d    = '0;
            state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_RUN;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= '0;
      seed_q   <= '0;
      word_q   <= '0;
      rem_q    <= '0;
      sh_q     <= '0;
      reseed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      word_q   <= word_d;
      rem_q    <= rem_d;
      sh_q     <= sh_d;
      reseed_q <= reseed_d;
      err_q    <= err_d;
      if (seed_we_i) seed_q <= seed_i;
    end
  end

  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_FINISH) && !abort_i;
  assign seed_err_o        = err_q;
  assign strm.word_o       = word_q;
  assign strm.word_valid_o = (state_q == S_PRESENT);

  // Start strobe is gated by reset so every output reads 0 while reset is held
  always_comb begin
    status_o    = '0;
    status_we_o = 1'b0;
    if (state_q == S_IDLE) begin
      if (start_i && reset_n) begin
        status_o    = ST_BUSY;
        status_we_o = 1'b1;
      end
    end else if (abort_i) begin
      status_o    = ST_ABORT;
      status_we_o = 1'b1;
    end else if (state_q == S_FINISH) begin
      status_o    = ST_DONE;
      status_we_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_prng_stream_engine.sv
// Directed bench: an 8-bit/SHIFTS=1 engine for the functional scenarios and a default
// 128-bit/SHIFTS=16 engine for latency and wide-word checks.
module tb_prng_stream_engine;

  logic clock, reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0]   seed8, count8;
  logic         seed_we8, start8, reseed8, abort8, busy8, done8, status_we8, err8;
  logic [2:0]   status8;
  logic [127:0] seed_w;
  logic [7:0]   count_w;
  logic         seed_we_w, start_w, reseed_w, abort_w, busy_w, done_w, status_we_w, err_w;
  logic [2:0]   status_w;

  prng_stream_engine_if #(.WIDTH(8))   s8 ();
  prng_stream_engine_if #(.WIDTH(128)) s128 ();

  prng_stream_engine #(
    .WIDTH (8),
    .TAPS  (8'hB8),
    .SHIFTS(1),
    .CNT_W (8)
  ) u_dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .seed_i     (seed8),
    .seed_we_i  (seed_we8),
    .start_i    (start8),
    .reseed_i   (reseed8),
    .count_i    (count8),
    .abort_i    (abort8),
    .strm       (s8.master),
    .busy_o     (busy8),
    .done_o     (done8),
    .status_o   (status8),
    .status_we_o(status_we8),
    .seed_err_o (err8)
  );

  prng_stream_engine u_dutw (
    .clock      (clock),
    .reset_n    (reset_n),
    .seed_i     (seed_w),
    .seed_we_i  (seed_we_w),
    .start_i    (start_w),
    .reseed_i   (reseed_w),
    .count_i    (count_w),
    .abort_i    (abort_w),
    .strm       (s128.master),
    .busy_o     (busy_w),
    .done_o     (done_w),
    .status_o   (status_w),
    .status_we_o(status_we_w),
    .seed_err_o (err_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Observations from the most recent burst
  logic [127:0] obs_words[$];
  logic [2:0]   obs_status[$];
  int           obs_done, obs_first, obs_done_cyc;
  bit           obs_timeout;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start and records handshakes, done pulses and status strobes until IDLE
  task automatic run_burst(input bit big, input bit rs, input int cnt, input int max_cyc);
    logic v, r, d, sw, b;
    logic [2:0]   st;
    logic [127:0] w;
    obs_words.delete();
    obs_status.delete();
    obs_done     = 0;
    obs_first    = -1;
    obs_done_cyc = -1;
    obs_timeout  = 1'b1;
    if (big) begin
      start_w = 1'b1; reseed_w = rs; count_w = 8'(cnt);
    end else begin
      start8 = 1'b1; reseed8 = rs; count8 = 8'(cnt);
    end
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clock);
      if (big) begin
        v = s128.word_valid_o; r = s128.word_ready_i; w = s128.word_o;
        d = done_w; sw = status_we_w; st = status_w; b = busy_w;
      end else begin
        v = s8.word_valid_o; r = s8.word_ready_i; w = {120'b0, s8.word_o};
        d = done8; sw = status_we8; st = status8; b = busy8;
      end
      if (v && obs_first < 0) obs_first = cyc;
      if (v && r) obs_words.push_back(w);
      if (d) begin
        obs_done++;
        obs_done_cyc = cyc;
      end
      if (sw) obs_status.push_back(st);
      if (cyc > 0 && !b) begin
        obs_timeout = 1'b0;
        break;
      end
      @(posedge clock);
      #1;
      start8  = 1'b0;
      start_w = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy8, done8, status8, status_we8, err8, s8.word_valid_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl8: got %b expected 0", {busy8, done8, status8, status_we8, err8});
    end
    n_checks++;
    if (s8.word_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_word8: got %h expected 00", s8.word_o);
    end
    n_checks++;
    if ({busy_w, done_w, status_w, status_we_w, err_w, s128.word_valid_o} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrlw: got %b expected 0", {busy_w, done_w, status_w, status_we_w});
    end
    n_checks++;
    if (s128.word_o !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_wordw: got %h expected 0", s128.word_o);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    logic [7:0] exp_w[4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    seed8 = 8'h01; seed_we8 = 1'b1;
    tick();
    seed_we8 = 1'b0;
    s8.word_ready_i = 1'b1;
    run_burst(1'b0, 1'b1, 4, 40);
    n_checks++;
    if (obs_timeout || obs_words.size() != 4) begin
      n_fail++;
      $display("FAIL burst_words: got %0d words (timeout %0d) expected 4", obs_words.size(),
               obs_timeout);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs_words[k] !== {120'b0, exp_w[k]}) begin
        n_fail++;
        $display("FAIL burst_word%0d: got %h expected %h", k, obs_words[k], exp_w[k]);
      end
    end
    n_checks++;
    if (obs_done != 1) begin
      n_fail++;
      $display("FAIL burst_done: got %0d pulses expected 1", obs_done);
    end
    n_checks++;
    if (obs_status.size() != 2 || obs_status[0] !== 3'b010 || obs_status[1] !== 3'b001) begin
      n_fail++;
      $display("FAIL burst_status: got %0d strobes first %b expected 010 then 001",
               obs_status.size(), obs_status[0]);
    end
    n_checks++;
    if (obs_first != 3) begin
      n_fail++;
      $display("FAIL burst_latency: got %0d cycles expected 3", obs_first);
    end
    n_checks++;
    if (err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_seed_err: got %b expected 0", err8);
    end
    tick();
  endtask

  // From 8'h11: taps B8 select bit4 only, parity 1, so the next word is 8'h23
  task automatic test_continue();
    run_burst(1'b0, 1'b0, 1, 20);
    n_checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 128'h23) begin
      n_fail++;
      $display("FAIL continue_word: got %h (%0d words) expected 23", obs_words[0],
               obs_words.size());
    end
    n_checks++;
    if (obs_done != 1) begin
      n_fail++;
      $display("FAIL continue_done: got %0d expected 1", obs_done);
    end
    tick();
  endtask

  task automatic test_zero_seed();
    seed8 = 8'h00; seed_we8 = 1'b1;
    tick();
    seed_we8 = 1'b0;
    run_burst(1'b0, 1'b1, 1, 20);
    n_checks++;
    if (err8 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_seed_err: got %b expected 1", err8);
    end
    n_checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 128'h02) begin
      n_fail++;
      $display("FAIL zero_seed_word: got %h expected 02", obs_words[0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    seed8 = 8'h01; seed_we8 = 1'b1;
    tick();
    seed_we8 = 1'b0;
    s8.word_ready_i = 1'b0;
    start8 = 1'b1; reseed8 = 1'b1; count8 = 8'd1;
    tick();
    start8 = 1'b0;
    @(negedge clock);
    while (!s8.word_valid_o && n < 10) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (s8.word_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid_rise: got %b expected 1", s8.word_valid_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if ({s8.word_valid_o, s8.word_o} !== {1'b1, 8'h02}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid %b word %h expected 1 02", i, s8.word_valid_o,
                 s8.word_o);
      end
    end
    s8.word_ready_i = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({done8, status_we8, status8} !== {1'b1, 1'b1, 3'b001}) begin
      n_fail++;
      $display("FAIL bp_finish: got done %b we %b status %b expected 1 1 001", done8,
               status_we8, status8);
    end
    @(negedge clock);
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: got busy %b expected 0", busy8);
    end
    tick();
  endtask

  task automatic test_abort();
    int n = 0;
    seed8 = 8'h01; seed_we8 = 1'b1;
    tick();
    seed_we8 = 1'b0;
    start8 = 1'b1; reseed8 = 1'b1; count8 = 8'd3;
    tick();
    start8 = 1'b0;
    @(negedge clock);
    while (!s8.word_valid_o && n < 10) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    n = 0;
    while (!s8.word_valid_o && n < 10) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (s8.word_o !== 8'h04) begin
      n_fail++;
      $display("FAIL abort_second_word: got %h expected 04", s8.word_o);
    end
    abort8 = 1'b1;
    #1;
    n_checks++;
    if ({status_we8, status8, done8} !== {1'b1, 3'b100, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_status: got we %b status %b done %b expected 1 100 0", status_we8,
               status8, done8);
    end
    @(posedge clock);
    #1;
    abort8 = 1'b0;
    n_checks++;
    if ({busy8, s8.word_valid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy %b valid %b expected 0 0", busy8, s8.word_valid_o);
    end
    @(negedge clock);
    n_checks++;
    if ({done8, status_we8} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_no_done: got done %b we %b expected 0 0", done8, status_we8);
    end
    tick();
    // LFSR stayed at 8'h04 through the abort
    run_burst(1'b0, 1'b0, 1, 20);
    n_checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 128'h08) begin
      n_fail++;
      $display("FAIL abort_lfsr_kept: got %h expected 08", obs_words[0]);
    end
    tick();
  endtask

  task automatic test_count_zero();
    run_burst(1'b0, 1'b1, 0, 10);
    n_checks++;
    if (obs_first != -1 || obs_words.size() != 0) begin
      n_fail++;
      $display("FAIL zero_count_valid: got first valid %0d expected none", obs_first);
    end
    n_checks++;
    if (obs_done != 1 || obs_done_cyc != 2) begin
      n_fail++;
      $display("FAIL zero_count_done: got %0d pulses at cycle %0d expected 1 at 2", obs_done,
               obs_done_cyc);
    end
    tick();
  endtask

  task automatic test_default_width();
    seed_w = 128'h1; seed_we_w = 1'b1;
    tick();
    seed_we_w = 1'b0;
    s128.word_ready_i = 1'b1;
    run_burst(1'b1, 1'b1, 2, 80);
    n_checks++;
    if (obs_first != 18) begin
      n_fail++;
      $display("FAIL wide_latency: got %0d cycles expected 18", obs_first);
    end
    n_checks++;
    if (obs_words.size() != 2 || obs_words[0] !== 128'h1_0000 ||
        obs_words[1] !== 128'h1_0000_0000) begin
      n_fail++;
      $display("FAIL wide_words: got %h %h expected 10000 100000000", obs_words[0],
               obs_words[1]);
    end
    tick();
    // Bit 127 is a tap: first shift feeds back 1, then 15 plain shifts
    seed_w = 128'h1 << 127; seed_we_w = 1'b1;
    tick();
    seed_we_w = 1'b0;
    run_burst(1'b1, 1'b1, 1, 40);
    n_checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 128'h8000) begin
      n_fail++;
      $display("FAIL wide_tap_word: got %h expected 8000", obs_words[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    seed_w = 128'h1; seed_we_w = 1'b1;
    tick();
    seed_we_w = 1'b0;
    start_w = 1'b1; reseed_w = 1'b1; count_w = 8'd2;
    tick();
    start_w = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy_w !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b expected 1", busy_w);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_w, s128.word_valid_o, status_we_w, done_w, err8} !== 5'b0 ||
        s128.word_o !== 128'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy %b err8 %b word %h expected all 0", busy_w, err8,
               s128.word_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
    seed8 = 8'h01; seed_we8 = 1'b1;
    tick();
    seed_we8 = 1'b0;
    run_burst(1'b0, 1'b1, 1, 20);
    n_checks++;
    if (obs_words.size() != 1 || obs_words[0] !== 128'h02 || err8 !== 1'b0 || obs_done != 1) begin
      n_fail++;
      $display("FAIL restart: got word %h err %b done %0d expected 02 0 1", obs_words[0], err8,
               obs_done);
    end
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    seed8 = '0; seed_we8 = 1'b0; start8 = 1'b0; reseed8 = 1'b0; count8 = '0; abort8 = 1'b0;
    seed_w = '0; seed_we_w = 1'b0; start_w = 1'b0; reseed_w = 1'b0; count_w = '0;
    abort_w = 1'b0;
    s8.word_ready_i = 1'b0;
    s128.word_ready_i = 1'b0;
    test_reset();
    test_burst();
    test_continue();
    test_zero_seed();
    test_backpressure();
    test_abort();
    test_count_zero();
    test_default_width();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
